// File: rtl/core3_pio_arbiter_if.sv
// ---------------------------------------------------------------------------
// core3_pio_arbiter_if
// Bundles the per-core Avalon-MM master signals and the shared PIO s1 port
// seen by core3_pio_arbiter.
//   slave  modport : arbiter view (takes core requests, drives PIO and responses)
//   master modport : environment view (cores + PIO model)
// Signals:
//   m_read/m_write       per-master request strobes
//   m_address/writedata  master i at [i*W +: W]
//   m_waitrequest        1 = request not accepted this cycle
//   m_readdatavalid      one-cycle pulse qualifying m_readdata for master i
//   m_readdata           shared read-data bus
//   s_address/read/write/writedata  to PIO
//   s_readdata           from PIO, valid one cycle after address
// ---------------------------------------------------------------------------
interface core3_pio_arbiter_if #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32
);
  logic [NUM_MASTERS-1:0]        m_read;
  logic [NUM_MASTERS-1:0]        m_write;
  logic [NUM_MASTERS*ADDR_W-1:0] m_address;
  logic [NUM_MASTERS*DATA_W-1:0] m_writedata;
  logic [NUM_MASTERS-1:0]        m_waitrequest;
  logic [NUM_MASTERS-1:0]        m_readdatavalid;
  logic [DATA_W-1:0]             m_readdata;
  logic [ADDR_W-1:0]             s_address;
  logic                          s_read;
  logic                          s_write;
  logic [DATA_W-1:0]             s_writedata;
  logic [DATA_W-1:0]             s_readdata;

  modport slave (
    input  m_read, m_write, m_address, m_writedata, s_readdata,
    output m_waitrequest, m_readdatavalid, m_readdata,
           s_address, s_read, s_write, s_writedata
  );

  modport master (
    output m_read, m_write, m_address, m_writedata, s_readdata,
    input  m_waitrequest, m_readdatavalid, m_readdata,
           s_address, s_read, s_write, s_writedata
  );
endinterface

// File: rtl/core3_pio_arbiter.sv
// ---------------------------------------------------------------------------
// core3_pio_arbiter
// Shares one PIO slave (1-cycle registered read latency) between NUM_MASTERS
// cores. One transaction in flight; losers see waitrequest; the winner gets
// readdatavalid one cycle after its read is accepted.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      core3_pio_arbiter_if.slave (core requests, PIO port, responses)
// Configuration macro:
//   PIO_ARB_FIXED_PRIO_EN  defined: fixed priority, master 0 highest,
//                          pointer held at 0. Undefined: round-robin.
// ---------------------------------------------------------------------------
module core3_pio_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  core3_pio_arbiter_if.slave        bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_win;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_is_rd;
  logic [DATA_W-1:0]   r_rdata;

  logic [NUM_MASTERS-1:0] w_req;
  logic [IDX_W-1:0]       w_pick;
  logic                   w_found;
  logic [IDX_W-1:0]       w_ptr_nxt;

  assign w_req = bus.m_read | bus.m_write;

  // Search from r_ptr upward with wrap. Walking k downward lets the
  // smallest offset (the first requester in search order) win last.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      if (w_req[(int'(r_ptr) + k) % NUM_MASTERS]) begin
        w_pick  = IDX_W'((int'(r_ptr) + k) % NUM_MASTERS);
        w_found = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_pick == IDX_W'(NUM_MASTERS - 1)) ? '0 : w_pick + IDX_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = r_is_rd ? RESP : IDLE;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_rd <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      // Request is captured at grant so a master withdrawing it afterwards
      // cannot abort the transfer. Read wins when both strobes are high.
      if (r_state == IDLE && w_found) begin
        r_win   <= w_pick;
        r_addr  <= bus.m_address[int'(w_pick)*ADDR_W +: ADDR_W];
        r_wdata <= bus.m_writedata[int'(w_pick)*DATA_W +: DATA_W];
        r_is_rd <= bus.m_read[w_pick];
`ifdef PIO_ARB_FIXED_PRIO_EN
        r_ptr   <= '0;
`else
        r_ptr   <= w_ptr_nxt;
`endif
      end
      if (r_state == RESP) r_rdata <= bus.s_readdata;
    end
  end

  always_comb begin
    bus.m_waitrequest   = '1;
    bus.m_readdatavalid = '0;
    if (r_state == ISSUE) bus.m_waitrequest[r_win]   = 1'b0;
    if (r_state == RESP)  bus.m_readdatavalid[r_win] = 1'b1;
  end

  // PIO data is returned straight through in the response cycle; the
  // register only keeps the bus stable between reads.
  assign bus.m_readdata  = (r_state == RESP) ? bus.s_readdata : r_rdata;
  assign bus.s_address   = (r_state == ISSUE) ? r_addr : '0;
  assign bus.s_read      = (r_state == ISSUE) &&  r_is_rd;
  assign bus.s_write     = (r_state == ISSUE) && !r_is_rd;
  assign bus.s_writedata = (r_state == ISSUE) ? r_wdata : '0;

endmodule
